a26_cart_loader: RTL and testbench

//  Parametrised cartridge download engine between hps_io ioctl and cart ROM storage.

---
 rtl/a26_cart_loader.sv | 196 +++++++++++++++++++
 tb/tb_a26_cart_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/a26_cart_loader.sv
// -----------------------------------------------------------------------------
// a26_cart_loader
// Cartridge download engine sitting between the hps_io ioctl interface and the
// cart ROM storage.
//
// Each accepted ioctl byte is written to storage through a simple we/ack
// handshake. hps_io is held off with ioctl_wait while the write is in flight.
// Downloads whose index does not match INDEX are ignored. Bytes addressed
// beyond the storage are dropped and flagged. A 16-bit running checksum is
// kept. At the end of the download the image can be padded with PAD_BYTE up
// to a power-of-two size, so the bank decoders always see a clean image.
// core_hold keeps the 2600 core in reset for the whole load.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   ioctl_download      download window from hps_io
//   ioctl_index         download target index
//   ioctl_wr            single-cycle byte strobe
//   ioctl_addr          byte address (25 bits)
//   ioctl_dout          byte data
//   ioctl_wait          back-pressure to hps_io
//   mem_addr/mem_data   storage write address / data
//   mem_we              write request, held until mem_ack
//   mem_ack             write accepted (may come in the same cycle as mem_we)
//   cart_size           raw loaded size (highest address written + 1)
//   size_log2           log2 of the padded image size
//   checksum            mod-2^16 sum of accepted download bytes
//   load_done           image complete and valid
//   load_error          overflow or empty download
//   core_hold           hold the console in reset while loading
// -----------------------------------------------------------------------------
module a26_cart_loader #(
  parameter int          ADDR_W   = 16,
  parameter logic [7:0]  INDEX    = 8'd1,
  parameter bit          PAD_EN   = 1'b1,
  parameter logic [7:0]  PAD_BYTE = 8'hFF,
  parameter int          MIN_LOG2 = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   cart_size,
  output logic [4:0]        size_log2,
  output logic [15:0]       checksum,
  output logic              load_done,
  output logic              load_error,
  output logic              core_hold
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, PAD, DONE} state_t;

  state_t            state, state_next;
  logic              dl_prev;
  logic              fall_pend;    // download ended while a write was in flight
  logic [ADDR_W-1:0] pad_last;     // last address written by the pad phase

  logic              dl_rise, dl_fall, start, in_range, accept, finish, err_now;
  logic [4:0]        lg_next;
  logic [ADDR_W:0]   pad_size, pad_last_w, addr_plus1;
  logic              needs_pad;

  // Smallest power of two covering size, clamped to [MIN_LOG2, ADDR_W].
  function automatic logic [4:0] pad_log2(input logic [ADDR_W:0] size);
    logic [4:0] r;
    r = 5'(MIN_LOG2);
    for (int i = MIN_LOG2; i < ADDR_W; i++)
      if (size > ((ADDR_W+1)'(1) << i)) r = 5'(i + 1);
    return r;
  endfunction

  assign dl_rise    = ioctl_download & ~dl_prev;
  assign dl_fall    = ~ioctl_download & dl_prev;
  assign start      = dl_rise && (ioctl_index == INDEX) && (state == IDLE || state == DONE);
  assign in_range   = (ioctl_addr >> ADDR_W) == 25'd0;
  assign accept     = (state == LOAD) && ioctl_wr && in_range;
  // A pending fall from the WRITE state is only acted on once back in LOAD.
  assign finish     = (state == LOAD) && !accept && (dl_fall || fall_pend);
  assign err_now    = load_error || (ioctl_wr && !in_range);
  assign lg_next    = pad_log2(cart_size);
  assign pad_size   = (ADDR_W+1)'(1) << lg_next;
  assign pad_last_w = pad_size - (ADDR_W+1)'(1);
  assign needs_pad  = PAD_EN && (cart_size < pad_size);
  assign addr_plus1 = {1'b0, mem_addr} + (ADDR_W+1)'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    ioctl_wait = 1'b0;
    core_hold  = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_next = LOAD;
      LOAD: begin
        core_hold = 1'b1;
        if (accept)
          state_next = WRITE;
        else if (finish)
          state_next = (cart_size != '0 && needs_pad) ? PAD : DONE;
      end
      WRITE: begin
        core_hold  = 1'b1;
        mem_we     = 1'b1;
        ioctl_wait = 1'b1;
        if (mem_ack) state_next = LOAD;
      end
      PAD: begin
        core_hold = 1'b1;
        mem_we    = 1'b1;
        if (mem_ack && mem_addr == pad_last) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dl_prev    <= 1'b0;
      fall_pend  <= 1'b0;
      pad_last   <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      cart_size  <= '0;
      size_log2  <= '0;
      checksum   <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      dl_prev <= ioctl_download;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cart_size  <= '0;
            checksum   <= '0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            fall_pend  <= 1'b0;
          end
        end
        LOAD: begin
          if (ioctl_wr && !in_range) load_error <= 1'b1;
          if (accept) begin
            mem_addr <= ioctl_addr[ADDR_W-1:0];
            mem_data <= ioctl_dout;
            if (dl_fall) fall_pend <= 1'b1;
          end else if (finish) begin
            fall_pend <= 1'b0;
            if (cart_size == '0) begin
              load_error <= 1'b1;
            end else begin
              size_log2 <= lg_next;
              pad_last  <= pad_last_w[ADDR_W-1:0];
              if (needs_pad) begin
                mem_addr <= cart_size[ADDR_W-1:0];
                mem_data <= PAD_BYTE;
              end else begin
                load_done <= !err_now;
              end
            end
          end
        end
        WRITE: begin
          if (dl_fall) fall_pend <= 1'b1;
          if (mem_ack) begin
            if (addr_plus1 > cart_size) cart_size <= addr_plus1;
            checksum <= checksum + {8'h00, mem_data};
          end
        end
        PAD: begin
          if (mem_ack) begin
            if (mem_addr == pad_last) load_done <= !load_error;
            else                      mem_addr  <= mem_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_a26_cart_loader.sv
module tb_a26_cart_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        ioctl_wait;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we, mem_ack;
  logic [16:0] cart_size;
  logic [4:0]  size_log2;
  logic [15:0] checksum;
  logic        load_done, load_error, core_hold;

  always #5 clk = ~clk;

  a26_cart_loader dut (
    .clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ack(mem_ack),
    .cart_size(cart_size), .size_log2(size_log2), .checksum(checksum),
    .load_done(load_done), .load_error(load_error), .core_hold(core_hold)
  );

  // Storage model: acks after ack_dly cycles of mem_we; records every write.
  int         ack_dly = 0;
  logic [3:0] ack_cnt = 4'd0;
  assign mem_ack = mem_we && (ack_cnt == 4'(ack_dly));
  always @(posedge clk) ack_cnt <= (mem_we && !mem_ack) ? ack_cnt + 4'd1 : 4'd0;

  logic [7:0] img [0:65535];
  int         tag [0:65535];
  int         epoch = 0;
  int         wr_total = 0, wait_total = 0;
  always @(posedge clk) begin
    if (mem_we && mem_ack) begin
      img[mem_addr] <= mem_data;
      tag[mem_addr] <= epoch;
      wr_total      <= wr_total + 1;
    end
    if (ioctl_wait) wait_total <= wait_total + 1;
  end

  int          n_cmp = 0, n_bad = 0, timeouts = 0;
  logic [15:0] exp_sum;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int a, input int seed);
    return 8'(a * 13 + seed + (a >> 8));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int a, input int seed);
    int g;
    ioctl_addr = 25'(a);
    ioctl_dout = pat(a, seed);
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    g = 0;
    while (ioctl_wait && g < 40) begin
      tick();
      g++;
    end
    if (g >= 40) timeouts++;
    if (a < 65536) exp_sum = exp_sum + {8'h00, pat(a, seed)};
  endtask

  task automatic send_range(input int lo, input int hi, input int seed);
    for (int a = lo; a < hi; a++) send_byte(a, seed);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (core_hold && g < 20000) begin
      tick();
      g++;
    end
    if (g >= 20000) timeouts++;
  endtask

  // Downloaded bytes at [0,n), pad bytes at [n,p), nothing written above p.
  task automatic check_image(input string name, input int n, input int p, input int seed);
    int bad;
    bad = 0;
    for (int a = 0; a < 65536; a++) begin
      if (a < n) begin
        if (tag[a] != epoch || img[a] != pat(a, seed)) bad++;
      end else if (a < p) begin
        if (tag[a] != epoch || img[a] != 8'hFF) bad++;
      end else if (tag[a] == epoch) begin
        bad++;
      end
    end
    check(name, 32'(bad), 32'd0);
  endtask

  int          w0, t0;
  logic [15:0] sum3;
  int          we_cycles;

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = 8'd0; ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) tick();
    check("rst_flags", {27'd0, ioctl_wait, mem_we, load_done, load_error, core_hold}, 32'd0);
    check("rst_size", {15'd0, cart_size}, 32'd0);
    check("rst_log2_sum", {11'd0, size_log2, checksum}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: 4096 bytes, immediate ack, exact power of two -> no pad
    epoch = 1; ack_dly = 0; exp_sum = '0;
    w0 = wr_total; t0 = wait_total;
    start_dl(8'd1);
    check("t1_hold", {31'd0, core_hold}, 32'd1);
    send_range(0, 4096, 1);
    check("t1_wait_cycles", 32'(wait_total - t0), 32'd4096);
    end_dl();
    wait_idle();
    check("t1_size", {15'd0, cart_size}, 32'd4096);
    check("t1_log2", {27'd0, size_log2}, 32'd12);
    check("t1_writes", 32'(wr_total - w0), 32'd4096);
    check("t1_sum", {16'd0, checksum}, {16'd0, exp_sum});
    check("t1_done_err", {30'd0, load_done, load_error}, 32'd2);
    check_image("t1_image", 4096, 4096, 1);

    // 2: 3000 bytes, ack 3 cycles after we -> 4 wait cycles per byte, pad to 4096
    epoch = 2; ack_dly = 3; exp_sum = '0;
    w0 = wr_total; t0 = wait_total;
    start_dl(8'd1);
    send_range(0, 3000, 2);
    check("t2_wait_cycles", 32'(wait_total - t0), 32'd12000);
    end_dl();
    wait_idle();
    check("t2_size", {15'd0, cart_size}, 32'd3000);
    check("t2_log2", {27'd0, size_log2}, 32'd12);
    check("t2_pad_writes", 32'(wr_total - w0 - 3000), 32'd1096);
    check("t2_sum", {16'd0, checksum}, {16'd0, exp_sum});
    check("t2_done", {30'd0, load_done, load_error}, 32'd2);
    check_image("t2_image", 3000, 4096, 2);

    // 3: 1000 bytes -> padded to MIN_LOG2 (2048)
    epoch = 3; ack_dly = 1; exp_sum = '0;
    w0 = wr_total;
    start_dl(8'd1);
    send_range(0, 1000, 3);
    end_dl();
    wait_idle();
    sum3 = exp_sum;
    check("t3_size", {15'd0, cart_size}, 32'd1000);
    check("t3_log2", {27'd0, size_log2}, 32'd11);
    check("t3_pad_writes", 32'(wr_total - w0 - 1000), 32'd1048);
    check("t3_sum", {16'd0, checksum}, {16'd0, sum3});
    check("t3_done", {30'd0, load_done, load_error}, 32'd2);
    check_image("t3_image", 1000, 2048, 3);

    // 4: non-matching index -> ignored, previous image state retained
    epoch = 4; ack_dly = 0;
    w0 = wr_total; t0 = wait_total;
    start_dl(8'd0);
    check("t4_hold", {31'd0, core_hold}, 32'd0);
    send_range(0, 4, 4);
    end_dl();
    repeat (3) tick();
    check("t4_writes", 32'(wr_total - w0), 32'd0);
    check("t4_wait", 32'(wait_total - t0), 32'd0);
    check("t4_size", {15'd0, cart_size}, 32'd1000);
    check("t4_sum", {16'd0, checksum}, {16'd0, sum3});
    check("t4_done_log2", {26'd0, load_done, size_log2}, {26'd0, 1'b1, 5'd11});

    // 5: out-of-range byte mid-download -> dropped, error, others still written
    epoch = 5; ack_dly = 0; exp_sum = '0;
    w0 = wr_total;
    start_dl(8'd1);
    send_range(0, 100, 5);
    send_byte(32'h10000, 5);
    check("t5_err_now", {31'd0, load_error}, 32'd1);
    send_range(100, 200, 5);
    end_dl();
    wait_idle();
    check("t5_size", {15'd0, cart_size}, 32'd200);
    check("t5_log2", {27'd0, size_log2}, 32'd11);
    check("t5_writes", 32'(wr_total - w0), 32'd2048);
    check("t5_sum", {16'd0, checksum}, {16'd0, exp_sum});
    check("t5_done_err", {30'd0, load_done, load_error}, 32'd1);
    check_image("t5_image", 200, 2048, 5);

    // 6a: reset in the middle of padding
    epoch = 6; ack_dly = 2; exp_sum = '0;
    start_dl(8'd1);
    send_range(0, 10, 6);
    end_dl();
    repeat (10) tick();
    check("t6_in_pad", {30'd0, core_hold, mem_we}, 32'd3);
    reset = 1'b1;
    tick();
    check("t6_rst_flags", {27'd0, ioctl_wait, mem_we, load_done, load_error, core_hold}, 32'd0);
    check("t6_rst_regs", {cart_size[15:0], checksum}, 32'd0);
    check("t6_rst_misc", {3'd0, cart_size[16], size_log2, mem_addr[7:0], mem_data, mem_addr[15:8]}, 32'd0);
    reset = 1'b0;
    w0 = wr_total;
    we_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_we) we_cycles++;
    end
    check("t6_no_we", 32'(we_cycles), 32'd0);
    check("t6_no_writes", 32'(wr_total - w0), 32'd0);

    // 6b: zero-length download
    epoch = 7; ack_dly = 0;
    w0 = wr_total;
    start_dl(8'd1);
    tick();
    end_dl();
    wait_idle();
    check("t6z_size", {15'd0, cart_size}, 32'd0);
    check("t6z_flags", {29'd0, load_done, load_error, core_hold}, 32'd2);
    check("t6z_writes", 32'(wr_total - w0), 32'd0);

    check("timeouts", 32'(timeouts), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
